// File: rtl/data_mem_bridge.sv
// M-stage data port to Wishbone B4 classic bridge: one bus cycle per load/store, stalls until ack.
// Optional bus-timeout abort is enabled by defining DMB_TIMEOUT_EN.
module data_mem_bridge #(
    parameter int unsigned DATA_WIDTH = 32
`ifdef DMB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    input  logic                    i_mem_write,
    input  logic [1:0]              i_size,
    input  logic                    i_unsigned,
    input  logic [DATA_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    o_stall,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_rdata_valid,
    output logic                    o_misaligned,
    output logic                    o_bus_err,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [3:0]              o_wb_sel,
    output logic [DATA_WIDTH-1:0]   o_wb_adr,
    output logic [DATA_WIDTH-1:0]   o_wb_dat,
    input  logic [DATA_WIDTH-1:0]   i_wb_dat,
    input  logic                    i_wb_ack
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    state_t                  state, state_nx;
    logic                    misaligned_now, accept, timeout_hit;
    logic [3:0]              req_sel;
    logic [DATA_WIDTH-1:0]   req_dat, load_ext;
    logic [1:0]              size_q, lo_q;
    logic                    uns_q;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;

    // size 11 behaves as word, so any size with bit 1 set needs word alignment
    assign misaligned_now = (i_size == 2'b01 && i_addr[0]) || (i_size[1] && i_addr[1:0] != 2'b00);
    assign accept         = (state == IDLE) && i_req_valid && !misaligned_now;
    assign o_stall        = rst && i_req_valid && (state != DONE) && !misaligned_now;
    assign o_misaligned   = rst && (state == IDLE) && i_req_valid && misaligned_now;

    // Lane selects and replicated write data for the incoming request
    always_comb begin
        req_sel = 4'hF;
        req_dat = i_wdata;
        case (i_size)
            2'b00: begin
                req_sel = 4'(4'b0001 << i_addr[1:0]);
                req_dat = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                req_sel = i_addr[1] ? 4'b1100 : 4'b0011;
                req_dat = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed lane of the read data
    always_comb begin
        case (lo_q)
            2'b00:   lane_byte = i_wb_dat[7:0];
            2'b01:   lane_byte = i_wb_dat[15:8];
            2'b10:   lane_byte = i_wb_dat[23:16];
            default: lane_byte = i_wb_dat[31:24];
        endcase
        lane_half = lo_q[1] ? i_wb_dat[31:16] : i_wb_dat[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = uns_q ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_ext = i_wb_dat;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = BUS;
            BUS:     if (i_wb_ack || timeout_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef DMB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;

    // An ack in the final wait cycle takes priority over the abort
    assign timeout_hit = (state == BUS) && !i_wb_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            o_bus_err <= 1'b0;
        end else begin
            o_bus_err <= timeout_hit;
            if (accept)
                wait_cnt <= '0;
            else if (state == BUS && !i_wb_ack)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_bus_err   = 1'b0;
`endif

    // Bus outputs are launched from IDLE and held until the cycle ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_sel      <= '0;
            o_wb_adr      <= '0;
            o_wb_dat      <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            size_q        <= '0;
            lo_q          <= '0;
            uns_q         <= 1'b0;
        end else begin
            o_rdata_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    o_wb_cyc <= 1'b1;
                    o_wb_stb <= 1'b1;
                    o_wb_we  <= i_mem_write;
                    o_wb_sel <= req_sel;
                    o_wb_adr <= {i_addr[DATA_WIDTH-1:2], 2'b00};
                    o_wb_dat <= req_dat;
                    size_q   <= i_size;
                    lo_q     <= i_addr[1:0];
                    uns_q    <= i_unsigned;
                end
                BUS: if (i_wb_ack || timeout_hit) begin
                    o_wb_cyc      <= 1'b0;
                    o_wb_stb      <= 1'b0;
                    o_wb_we       <= 1'b0;
                    o_wb_sel      <= '0;
                    o_wb_adr      <= '0;
                    o_wb_dat      <= '0;
                    o_rdata_valid <= 1'b1;
                    o_rdata       <= (i_wb_ack && !o_wb_we) ? load_ext : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed self-checking bench for data_mem_bridge; the timeout case runs only with DMB_TIMEOUT_EN.
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_mem_write, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_rdata_valid, o_misaligned, o_bus_err;
    logic [31:0] o_rdata;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, i_wb_ack;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_adr, o_wb_dat, i_wb_dat;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

`ifdef DMB_TIMEOUT_EN
    data_mem_bridge #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
`else
    data_mem_bridge #(.DATA_WIDTH(32)) dut (
`endif
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_mem_write(i_mem_write), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one access at a negedge; slave acks in BUS cycle ack_after (0 = first)
    task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int ack_after,
                          input logic [31:0] rd, input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                          input logic [31:0] exp_rd);
        int stalls;
        stalls      = 0;
        i_req_valid = 1'b1; i_mem_write = we; i_size = size; i_unsigned = uns;
        i_addr      = addr; i_wdata = wdata; i_wb_ack = 1'b0;
        #1;
        chk({tag, ".req_cyc"}, 32'(o_wb_cyc), 32'd0);
        chk({tag, ".req_rvalid"}, 32'(o_rdata_valid), 32'd0);
        chk({tag, ".req_misal"}, 32'(o_misaligned), 32'd0);
        if (o_stall) stalls++;
        cyc_step();
        for (int c = 0; c <= ack_after; c++) begin
            chk({tag, ".cyc"}, 32'(o_wb_cyc), 32'd1);
            chk({tag, ".stb"}, 32'(o_wb_stb), 32'd1);
            chk({tag, ".we"}, 32'(o_wb_we), 32'(we));
            chk({tag, ".sel"}, 32'(o_wb_sel), 32'(exp_sel));
            chk({tag, ".adr"}, o_wb_adr, {addr[31:2], 2'b00});
            if (we) chk({tag, ".dat"}, o_wb_dat, exp_dat);
            if (c == ack_after) begin
                i_wb_ack = 1'b1;
                i_wb_dat = rd;
            end
            #1;
            if (o_stall) stalls++;
            cyc_step();
            i_wb_ack = 1'b0;
            i_wb_dat = 32'h5555_AAAA;
        end
        #1;
        chk({tag, ".done_cyc"}, 32'(o_wb_cyc), 32'd0);
        chk({tag, ".rvalid"}, 32'(o_rdata_valid), 32'd1);
        chk({tag, ".rdata"}, o_rdata, exp_rd);
        chk({tag, ".done_stall"}, 32'(o_stall), 32'd0);
        chk({tag, ".bus_err"}, 32'(o_bus_err), 32'd0);
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(ack_after + 2));
        last_rdata = exp_rd;
        cyc_step();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; i_req_valid = 1'b0; i_mem_write = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
        i_addr = '0; i_wdata = '0; i_wb_ack = 1'b0; i_wb_dat = '0;
        repeat (3) @(negedge clk);
        chk("rst.cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst.stb", 32'(o_wb_stb), 32'd0);
        chk("rst.sel", 32'(o_wb_sel), 32'd0);
        chk("rst.adr", o_wb_adr, 32'd0);
        chk("rst.rdata", o_rdata, 32'd0);
        chk("rst.rvalid", 32'(o_rdata_valid), 32'd0);
        chk("rst.stall", 32'(o_stall), 32'd0);
        rst = 1'b1;
        cyc_step();

        access("lw100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 32'h8765_4321, 4'hF, 32'h0, 32'h8765_4321);
        // Back-to-back: next request issued in the IDLE cycle after DONE
        access("lb103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h8012_3456, 4'b1000, 32'h0, 32'hFFFF_FF80);
        access("lbu103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h8012_3456, 4'b1000, 32'h0, 32'h0000_0080);
        access("sh202", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 1, 32'hFFFF_FFFF, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        access("lh202", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 0, 32'h9ABC_1234, 4'b1100, 32'h0, 32'hFFFF_9ABC);
        access("lhu200", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 0, 32'h9ABC_8001, 4'b0011, 32'h0, 32'h0000_8001);
        access("sb101", 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00A5, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        access("sw104", 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 1, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'h0);
        access("lw_sz3", 1'b0, 2'b11, 1'b0, 32'h108, 32'h0, 0, 32'h1122_3344, 4'hF, 32'h0, 32'h1122_3344);
        access("lbu102", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 0, 32'h00C3_0000, 4'b0100, 32'h0, 32'h0000_00C3);

        // Misaligned word: rejected in the request cycle without a bus cycle
        i_req_valid = 1'b1; i_mem_write = 1'b0; i_size = 2'b10; i_addr = 32'h101;
        #1;
        chk("misw.flag", 32'(o_misaligned), 32'd1);
        chk("misw.stall", 32'(o_stall), 32'd0);
        cyc_step();
        chk("misw.cyc", 32'(o_wb_cyc), 32'd0);
        chk("misw.rdata", o_rdata, last_rdata);
        i_size = 2'b01; i_addr = 32'h203;
        #1;
        chk("mish.flag", 32'(o_misaligned), 32'd1);
        cyc_step();
        chk("mish.cyc", 32'(o_wb_cyc), 32'd0);
        i_req_valid = 1'b0;
        #1;
        chk("mis.clear", 32'(o_misaligned), 32'd0);

        // Stray ack while idle is ignored
        i_wb_ack = 1'b1; i_wb_dat = 32'hFFFF_FFFF;
        cyc_step();
        i_wb_ack = 1'b0;
        #1;
        chk("stray.cyc", 32'(o_wb_cyc), 32'd0);
        chk("stray.rvalid", 32'(o_rdata_valid), 32'd0);
        chk("stray.rdata", o_rdata, last_rdata);
        chk("stray.stall", 32'(o_stall), 32'd0);
        cyc_step();

        // Reset while awaiting ack drops the cycle immediately
        i_req_valid = 1'b1; i_mem_write = 1'b1; i_size = 2'b00; i_addr = 32'h102; i_wdata = 32'h5A;
        cyc_step();
        chk("mrst.pre_cyc", 32'(o_wb_cyc), 32'd1);
        rst = 1'b0;
        #1;
        chk("mrst.cyc", 32'(o_wb_cyc), 32'd0);
        chk("mrst.stb", 32'(o_wb_stb), 32'd0);
        chk("mrst.stall", 32'(o_stall), 32'd0);
        chk("mrst.sel", 32'(o_wb_sel), 32'd0);
        cyc_step();
        chk("mrst.rdata", o_rdata, 32'd0);
        rst = 1'b1;
        access("sb_after_rst", 1'b1, 2'b00, 1'b0, 32'h102, 32'h5A, 0, 32'h0, 4'b0100, 32'h5A5A_5A5A, 32'h0);

`ifdef DMB_TIMEOUT_EN
        // Unanswered load aborts after four BUS cycles
        access("lw_pre_to", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 32'h1234_5678, 4'hF, 32'h0, 32'h1234_5678);
        i_req_valid = 1'b1; i_mem_write = 1'b0; i_size = 2'b10; i_addr = 32'h304; i_wb_ack = 1'b0;
        cyc_step();
        for (int c = 0; c < 4; c++) begin
            chk("to.cyc", 32'(o_wb_cyc), 32'd1);
            cyc_step();
        end
        chk("to.cyc_drop", 32'(o_wb_cyc), 32'd0);
        chk("to.bus_err", 32'(o_bus_err), 32'd1);
        chk("to.rvalid", 32'(o_rdata_valid), 32'd1);
        chk("to.rdata", o_rdata, 32'd0);
        cyc_step();
        i_req_valid = 1'b0;
        #1;
        chk("to.err_clear", 32'(o_bus_err), 32'd0);
`endif

        i_req_valid = 1'b0;
        cyc_step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
